mem_responder: RTL and testbench

//  Memory-side target of the processor's 8-bit address / 16-bit data memory bus.

---
 rtl/mem_responder_pkg.sv | 17 +
 rtl/mem_store.sv | 23 ++
 rtl/mem_responder.sv | 97 +++++++++
 tb/tb_mem_responder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory-bus responder: default widths, IO decode
// address, FSM state encoding and bus opcodes.
package mem_responder_pkg;
    localparam int unsigned DEF_AW      = 8;
    localparam int unsigned DEF_DW      = 16;
    localparam logic [7:0]  DEF_IO_ADDR = 8'hFF;
    localparam int unsigned WCNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } respState;

    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;
endpackage

// File: rtl/mem_store.sv
// Word-addressed program/data store: synchronous write, combinational read.
// Contents are never reset so externally preloaded data survives reset.
module mem_store
    import mem_responder_pkg::*;
#(
    parameter int unsigned AW = DEF_AW,
    parameter int unsigned DW = DEF_DW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/mem_responder.sv
// Memory-bus target: one access at a time with programmable wait states,
// backing store plus a memory-mapped output register at IO_ADDR.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned   AW          = DEF_AW,
    parameter int unsigned   DW          = DEF_DW,
    parameter int unsigned   WAIT_CYCLES = 2,
    parameter logic [AW-1:0] IO_ADDR     = DEF_IO_ADDR
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mem_req,
    input  logic          mem_rw,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] mem_rdata,
    output logic          mem_ready,
    output logic          busy,
    output logic [DW-1:0] io_out,
    output logic          io_valid,
    output logic [15:0]   acc_count
);
    localparam logic [WCNT_W-1:0] WAIT_INIT = WCNT_W'(WAIT_CYCLES);

    respState          state, nextState;
    logic              rwQ;
    logic [AW-1:0]     addrQ;
    logic [DW-1:0]     wdataQ;
    logic [WCNT_W-1:0] wcnt;
    logic              accept, loadRdata, storeWe, srcRw;
    logic [AW-1:0]     srcAddr;
    logic [DW-1:0]     storeRdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (mem_req) nextState = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT: if (wcnt == WCNT_W'(1)) nextState = RESP;
            RESP: nextState = IDLE;
            default: nextState = IDLE;
        endcase

        accept    = (state == IDLE) && mem_req;
        // With zero wait states RESP follows accept directly, so the read
        // address comes straight off the bus rather than from the capture.
        srcAddr   = (state == IDLE) ? mem_addr : addrQ;
        srcRw     = (state == IDLE) ? mem_rw : rwQ;
        loadRdata = (nextState == RESP) && (state != RESP) && (srcRw == RD);

        mem_ready = (state == RESP);
        busy      = (state != IDLE);
        io_valid  = (state == RESP) && (rwQ == WR) && (addrQ == IO_ADDR);
        storeWe   = (state == RESP) && (rwQ == WR) && (addrQ != IO_ADDR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rwQ       <= RD;
            addrQ     <= '0;
            wdataQ    <= '0;
            wcnt      <= '0;
            mem_rdata <= '0;
            io_out    <= '0;
            acc_count <= '0;
        end else begin
            if (accept) begin
                rwQ    <= mem_rw;
                addrQ  <= mem_addr;
                wdataQ <= mem_wdata;
                wcnt   <= WAIT_INIT;
            end else if (state == WAIT) begin
                wcnt <= wcnt - WCNT_W'(1);
            end
            if (loadRdata) mem_rdata <= (srcAddr == IO_ADDR) ? io_out : storeRdata;
            if (io_valid) io_out <= wdataQ;
            if (state == RESP) acc_count <= acc_count + 16'd1;
        end
    end

    mem_store #(
        .AW (AW),
        .DW (DW)
    ) r1 (
        .clk   (clk),
        .we    (storeWe),
        .waddr (addrQ),
        .wdata (wdataQ),
        .raddr (srcAddr),
        .rdata (storeRdata)
    );
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed table, multi-cycle corner
// sequences and randomized accesses against a behavioural memory model.
module tb_mem_responder;
    localparam int unsigned W = 2;

    logic        clk, rst;
    logic        memReq, memReq0, memRw;
    logic [7:0]  memAddr;
    logic [15:0] memWdata;
    logic [15:0] rdata, ioOut, accCount, rdata0, ioOut0, accCount0;
    logic        ready, busy, ioValid, ready0, busy0, ioValid0;

    mem_responder #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .mem_req(memReq), .mem_rw(memRw),
        .mem_addr(memAddr), .mem_wdata(memWdata), .mem_rdata(rdata),
        .mem_ready(ready), .busy(busy), .io_out(ioOut), .io_valid(ioValid),
        .acc_count(accCount)
    );

    mem_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .mem_req(memReq0), .mem_rw(memRw),
        .mem_addr(memAddr), .mem_wdata(memWdata), .mem_rdata(rdata0),
        .mem_ready(ready0), .busy(busy0), .io_out(ioOut0), .io_valid(ioValid0),
        .acc_count(accCount0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: plain array store, output register, access counter.
    logic [15:0] refMem [256];
    logic [15:0] refIo;
    logic [15:0] refAcc;

    function automatic logic [15:0] modelApply(input logic rw, input logic [7:0] addr,
                                               input logic [15:0] wd);
        logic [15:0] r;
        r = '0;
        if (rw) begin
            if (addr == 8'hFF) refIo = wd;
            else               refMem[addr] = wd;
        end else begin
            r = (addr == 8'hFF) ? refIo : refMem[addr];
        end
        refAcc = refAcc + 16'd1;
        return r;
    endfunction

    task automatic doTxn(input logic rw, input logic [7:0] addr, input logic [15:0] wd,
                         input bit scramble, output logic [15:0] rd, output int lat,
                         output int ioPulses);
        rd = '0;
        lat = 0;
        ioPulses = 0;
        @(negedge clk);
        memReq = 1'b1; memRw = rw; memAddr = addr; memWdata = wd;
        @(posedge clk);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (scramble && lat == 1) begin
                memReq   = 1'b0;
                memRw    = 1'($urandom_range(0, 1));
                memAddr  = 8'($urandom);
                memWdata = 16'($urandom);
            end
            if (ioValid) ioPulses++;
            if (ready) begin
                rd = rdata;
                break;
            end
        end
        memReq = 1'b0;
        @(negedge clk);
        if (ioValid) ioPulses++;
    endtask

    typedef struct {
        logic        rw;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] expRdata;
        logic [15:0] expIo;
        int          expPulses;
    } vecT;

    vecT vecs[6];

    initial begin
        logic [15:0] rd, savedFF, saved30, saved0D, wd, expRd;
        logic [7:0]  a;
        logic        rw;
        int          lat, pulses, readyCount;
        bit          scr;

        rst = 1'b1; memReq = 1'b0; memReq0 = 1'b0; memRw = 1'b0;
        memAddr = '0; memWdata = '0;
        for (int i = 0; i < 256; i++) begin
            refMem[i] = 16'($urandom);
            dut.r1.mem[i] = refMem[i];
        end
        refMem[8'h0D] = 16'h0042;
        dut.r1.mem[8'h0D] = 16'h0042;
        dut0.r1.mem[8'h0D] = 16'h0042;
        refIo = '0;
        refAcc = '0;
        savedFF = refMem[8'hFF];

        vecs[0] = '{1'b0, 8'h0D, 16'h0000, 16'h0042, 16'h0000, 0};
        vecs[1] = '{1'b1, 8'h20, 16'hBEEF, 16'h0000, 16'h0000, 0};
        vecs[2] = '{1'b0, 8'h20, 16'h0000, 16'hBEEF, 16'h0000, 0};
        vecs[3] = '{1'b1, 8'hFF, 16'h1234, 16'h0000, 16'h1234, 1};
        vecs[4] = '{1'b0, 8'hFF, 16'h0000, 16'h1234, 16'h1234, 0};
        vecs[5] = '{1'b0, 8'h0D, 16'h0000, 16'h0042, 16'h1234, 0};

        repeat (2) @(negedge clk);
        check("reset_rdata", 32'(rdata), 32'h0);
        check("reset_ready", 32'(ready), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_io_out", 32'(ioOut), 32'h0);
        check("reset_io_valid", 32'(ioValid), 32'h0);
        check("reset_acc", 32'(accCount), 32'h0);
        rst = 1'b0;

        // Directed table: read preload, write/read-back, IO write/read.
        for (int i = 0; i < 6; i++) begin
            doTxn(vecs[i].rw, vecs[i].addr, vecs[i].wdata, 1'b0, rd, lat, pulses);
            void'(modelApply(vecs[i].rw, vecs[i].addr, vecs[i].wdata));
            check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(W + 1));
            if (!vecs[i].rw) check($sformatf("tbl%0d_rdata", i), 32'(rd), 32'(vecs[i].expRdata));
            check($sformatf("tbl%0d_io_out", i), 32'(ioOut), 32'(vecs[i].expIo));
            check($sformatf("tbl%0d_io_pulses", i), 32'(pulses), 32'(vecs[i].expPulses));
            check($sformatf("tbl%0d_acc", i), 32'(accCount), 32'(i + 1));
            if (vecs[i].rw && vecs[i].addr != 8'hFF)
                check($sformatf("tbl%0d_store", i), 32'(dut.r1.mem[vecs[i].addr]), 32'(vecs[i].wdata));
        end
        check("io_store_untouched", 32'(dut.r1.mem[8'hFF]), 32'(savedFF));

        // Zero wait states, request held: ready every second cycle.
        @(negedge clk);
        memReq0 = 1'b1; memRw = 1'b0; memAddr = 8'h0D;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("w0_ready_%0d", k), 32'(ready0), 32'(k % 2));
            if (ready0) check($sformatf("w0_rdata_%0d", k), 32'(rdata0), 32'h0042);
        end
        memReq0 = 1'b0;
        check("w0_acc", 32'(accCount0), 32'd4);

        // Counter wrap.
        @(negedge clk);
        dut.acc_count = 16'hFFFF;
        refAcc = 16'hFFFF;
        doTxn(1'b0, 8'h0D, 16'h0, 1'b0, rd, lat, pulses);
        void'(modelApply(1'b0, 8'h0D, 16'h0));
        check("wrap_acc", 32'(accCount), 32'h0);
        check("wrap_rdata", 32'(rd), 32'h0042);

        // Randomized accesses, some with inputs disturbed mid-transaction.
        for (int n = 0; n < 60; n++) begin
            rw  = 1'($urandom_range(0, 1));
            a   = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            wd  = 16'($urandom);
            scr = ($urandom_range(0, 3) == 0);
            doTxn(rw, a, wd, scr, rd, lat, pulses);
            expRd = modelApply(rw, a, wd);
            check($sformatf("rnd%0d_latency", n), 32'(lat), 32'(W + 1));
            if (!rw) check($sformatf("rnd%0d_rdata", n), 32'(rd), 32'(expRd));
            check($sformatf("rnd%0d_io_pulses", n), 32'(pulses), 32'((rw && a == 8'hFF) ? 1 : 0));
            check($sformatf("rnd%0d_io_out", n), 32'(ioOut), 32'(refIo));
            check($sformatf("rnd%0d_acc", n), 32'(accCount), 32'(refAcc));
        end
        for (int i = 0; i < 256; i++)
            check($sformatf("store_%02h", i), 32'(dut.r1.mem[i]), 32'(refMem[i]));

        // Reset during WAIT aborts the write.
        saved30 = refMem[8'h30];
        saved0D = refMem[8'h0D];
        @(negedge clk);
        memReq = 1'b1; memRw = 1'b1; memAddr = 8'h30; memWdata = ~saved30;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        check("abort_rdata", 32'(rdata), 32'h0);
        check("abort_ready", 32'(ready), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_io_out", 32'(ioOut), 32'h0);
        check("abort_io_valid", 32'(ioValid), 32'h0);
        check("abort_acc", 32'(accCount), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        memReq = 1'b0;
        readyCount = 0;
        repeat (6) begin
            @(negedge clk);
            if (ready) readyCount++;
        end
        check("abort_no_ready", 32'(readyCount), 32'h0);
        check("abort_store30", 32'(dut.r1.mem[8'h30]), 32'(saved30));
        check("abort_store0D", 32'(dut.r1.mem[8'h0D]), 32'(saved0D));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end
endmodule
